alu_ctrl: RTL and testbench

Sequential command front end for the combinational `alu`. It owns a small register file and accepts register-to-register commands over a valid/ready handshake. It drives the ALU's `A`/`B`/`sel` inputs from registered operands, writes the ALU result back, and returns the result plus flags over a second valid/ready handshake. It sits between the test/stimulus source (or later a decode stage) and one `alu` instance.

---
 rtl/alu_ctrl.sv | 112 +++++++++++
 tb/tb_alu_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Command front end for the combinational alu: register file, operand staging,
// result/flag writeback and a valid/ready response port.
module alu_ctrl #(
  parameter int nbit = 4,
  parameter int RW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_ld,
  input  logic [2:0]      cmd_op,
  input  logic [nbit-1:0] cmd_imm,
  input  logic [RW-1:0]   cmd_rd,
  input  logic [RW-1:0]   cmd_rs1,
  input  logic [RW-1:0]   cmd_rs2,
  output logic [nbit-1:0] alu_a,
  output logic [nbit-1:0] alu_b,
  output logic [2:0]      alu_sel,
  input  logic [nbit-1:0] alu_result,
  input  logic            alu_overflow,
  input  logic            alu_zero,
  input  logic            alu_carry,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [nbit-1:0] rsp_data,
  output logic [2:0]      rsp_flags
);

  localparam int DEPTH = 1 << RW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            w_accept;
  logic [nbit-1:0] r_regFile [DEPTH];
  logic [nbit-1:0] r_aluA;
  logic [nbit-1:0] r_aluB;
  logic [2:0]      r_aluSel;
  logic [RW-1:0]   r_rd;
  logic [nbit-1:0] r_rspData;
  logic [2:0]      r_rspFlags;

  assign w_accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nextState = cmd_ld ? RESP : EXEC;
      EXEC: w_nextState = RESP;
      RESP: if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Reset forces IDLE asynchronously, so rsp_valid falls as soon as rst rises.
  always_comb begin
    cmd_ready = (r_state == IDLE) && !rst;
    rsp_valid = (r_state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regFile[i] <= '0;
      r_aluA     <= '0;
      r_aluB     <= '0;
      r_aluSel   <= '0;
      r_rd       <= '0;
      r_rspData  <= '0;
      r_rspFlags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (cmd_ld) begin
              r_regFile[cmd_rd] <= cmd_imm;
              r_rspData         <= cmd_imm;
            end else begin
              r_aluA   <= r_regFile[cmd_rs1];
              r_aluB   <= r_regFile[cmd_rs2];
              r_aluSel <= cmd_op;
              r_rd     <= cmd_rd;
            end
          end
        end
        EXEC: begin
          r_regFile[r_rd] <= alu_result;
          r_rspData       <= alu_result;
          r_rspFlags      <= {alu_overflow, alu_zero, alu_carry};
        end
        default: ;
      endcase
    end
  end

  assign alu_a     = r_aluA;
  assign alu_b     = r_aluB;
  assign alu_sel   = r_aluSel;
  assign rsp_data  = r_rspData;
  assign rsp_flags = r_rspFlags;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural alu attached; expected
// responses go into a queue that a negedge monitor drains on each handshake.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_ld;
  logic [2:0] cmd_op;
  logic [3:0] cmd_imm;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       alu_overflow, alu_zero, alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [2:0] rsp_flags;

  typedef struct {
    logic [3:0] data;
    logic [2:0] flags;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  alu_ctrl #(.nbit(4), .RW(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  // Behavioural alu; subtraction carry is the carry-out of A + ~B + 1.
  always_comb begin
    logic [4:0] wide;
    wide         = '0;
    alu_result   = '0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_sel)
      3'b000: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = wide[3:0];
        alu_carry    = wide[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      3'b001: begin
        wide         = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_result   = wide[3:0];
        alu_carry    = wide[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      3'b010: alu_result = ~alu_a;
      3'b011: alu_result = alu_a & alu_b;
      3'b100: alu_result = alu_a | alu_b;
      3'b101: alu_result = alu_a ^ alu_b;
      3'b110: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 4'd1 : 4'd0;
      default: alu_result = (alu_a == alu_b) ? 4'd1 : 4'd0;
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResponse", 32'(rsp_data), 32'hDEAD);
      end else begin
        e = expQ.pop_front();
        checkOutput("rspData", 32'(rsp_data), 32'(e.data));
        checkOutput("rspFlags", 32'(rsp_flags), 32'(e.flags));
      end
    end
  end

  // Issues one command; holdCycles>0 stalls the response while a second
  // command is presented, which must be ignored.
  task automatic applyStimulus(input logic ld, input logic [2:0] op, input logic [3:0] imm,
                               input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                               input logic [3:0] expData, input logic [2:0] expFlags,
                               input int holdCycles);
    int lat;
    int cnt;
    exp_t e;
    cnt = 0;
    while (!cmd_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!cmd_ready) checkOutput("cmdReadyTimeout", 32'(cmd_ready), 32'd1);
    rsp_ready = (holdCycles == 0);
    cmd_valid = 1'b1;
    cmd_ld    = ld;
    cmd_op    = op;
    cmd_imm   = imm;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    e.data    = expData;
    e.flags   = expFlags;
    expQ.push_back(e);
    @(posedge clk); #1;
    if (holdCycles > 0) begin
      cmd_ld  = 1'b1;
      cmd_imm = 4'd9;
      cmd_rd  = 2'd3;
    end else begin
      cmd_valid = 1'b0;
    end
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("rspLatency", 32'(lat), ld ? 32'd1 : 32'd2);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("holdValid", 32'(rsp_valid), 32'd1);
      checkOutput("holdData", 32'(rsp_data), 32'(expData));
      checkOutput("holdFlags", 32'(rsp_flags), 32'(expFlags));
      checkOutput("holdCmdReady", 32'(cmd_ready), 32'd0);
    end
    if (holdCycles > 0) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (rsp_valid && cnt < 10);
    if (rsp_valid) checkOutput("handshakeTimeout", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_ld    = 1'b0;
    cmd_op    = 3'b000;
    cmd_imm   = 4'd0;
    cmd_rd    = 2'd0;
    cmd_rs1   = 2'd0;
    cmd_rs2   = 2'd0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("cmdReadyInReset", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("resetCmdReady", 32'(cmd_ready), 32'd1);
    checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("resetRspData", 32'(rsp_data), 32'd0);
    checkOutput("resetRspFlags", 32'(rsp_flags), 32'd0);
    checkOutput("resetAluA", 32'(alu_a), 32'd0);
    checkOutput("resetAluB", 32'(alu_b), 32'd0);
    checkOutput("resetAluSel", 32'(alu_sel), 32'd0);
    @(posedge clk); #1;

    // ld, op, imm, rd, rs1, rs2, expData, expFlags, hold
    applyStimulus(1'b0, 3'b000, 4'd0, 2'd2, 2'd0, 2'd1, 4'b0000, 3'b010, 0);
    applyStimulus(1'b1, 3'b000, 4'd7, 2'd0, 2'd0, 2'd0, 4'b0111, 3'b010, 0);
    applyStimulus(1'b1, 3'b000, 4'd1, 2'd1, 2'd0, 2'd0, 4'b0001, 3'b010, 0);
    applyStimulus(1'b0, 3'b000, 4'd0, 2'd2, 2'd0, 2'd1, 4'b1000, 3'b100, 0);
    applyStimulus(1'b1, 3'b000, 4'b1000, 2'd0, 2'd0, 2'd0, 4'b1000, 3'b100, 0);
    applyStimulus(1'b1, 3'b000, 4'd1, 2'd1, 2'd0, 2'd0, 4'b0001, 3'b100, 0);
    applyStimulus(1'b0, 3'b001, 4'd0, 2'd3, 2'd0, 2'd1, 4'b0111, 3'b101, 0);
    applyStimulus(1'b1, 3'b000, 4'd3, 2'd2, 2'd0, 2'd0, 4'b0011, 3'b101, 0);
    applyStimulus(1'b1, 3'b000, 4'b1111, 2'd0, 2'd0, 2'd0, 4'b1111, 3'b101, 0);
    applyStimulus(1'b1, 3'b000, 4'd1, 2'd1, 2'd0, 2'd0, 4'b0001, 3'b101, 0);
    applyStimulus(1'b0, 3'b110, 4'd0, 2'd0, 2'd0, 2'd1, 4'b0001, 3'b000, 0);
    checkOutput("sltAluSel", 32'(alu_sel), 32'b110);
    checkOutput("sltAluA", 32'(alu_a), 32'hF);
    checkOutput("sltAluB", 32'(alu_b), 32'h1);
    applyStimulus(1'b0, 3'b000, 4'd0, 2'd1, 2'd0, 2'd0, 4'b0010, 3'b000, 0);
    applyStimulus(1'b1, 3'b000, 4'd4, 2'd2, 2'd0, 2'd0, 4'b0100, 3'b000, 0);
    checkOutput("aluAHeldAfterLoad", 32'(alu_a), 32'h1);

    // r0=1, r1=2: xor held for 5 cycles with a load r3=9 pending, then r3+r3 must use r3=7
    applyStimulus(1'b0, 3'b101, 4'd0, 2'd2, 2'd0, 2'd1, 4'b0011, 3'b000, 5);
    applyStimulus(1'b0, 3'b000, 4'd0, 2'd0, 2'd3, 2'd3, 4'b1110, 3'b100, 0);

    // Reset during EXEC aborts the add and clears the register file
    applyStimulus(1'b1, 3'b000, 4'd5, 2'd2, 2'd0, 2'd0, 4'b0101, 3'b100, 0);
    cmd_valid = 1'b1;
    cmd_ld    = 1'b0;
    cmd_op    = 3'b000;
    cmd_rd    = 2'd2;
    cmd_rs1   = 2'd0;
    cmd_rs2   = 2'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("abortRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("abortCmdReady", 32'(cmd_ready), 32'd0);
    checkOutput("abortRspData", 32'(rsp_data), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'b000, 4'd0, 2'd3, 2'd2, 2'd0, 4'b0000, 3'b010, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
